// File: rtl/motor_step_driver.sv
// ---------------------------------------------------------------------------
// motor_step_driver
//
// Command consumer for the 5-key entry block. On a rising edge of Start it
// captures the one-hot motor select and a 3-digit BCD target (0..999),
// converts the target to binary and drives Step/Dir on the selected motor
// until that motor's 10-bit absolute position equals the target.
// Six motors are supported, each with its own position register.
//
// Optional feature (compile-time macro):
//   SOFT_LIMIT_EN  - when defined, targets above LIMIT are rejected with Err.
//                    When undefined, LIMIT is ignored.
//
// Parameters:
//   STEP_DIV  sysclk cycles per Step half-period (min 1)
//   LIMIT     soft upper position limit (used only with SOFT_LIMIT_EN)
//
// Ports:
//   sysclk   in   1  system clock, rising edge
//   rst      in   1  asynchronous reset, active-high
//   Start    in   1  command strobe (level), rising edge starts a command
//   TValue0  in   4  target hundreds digit (BCD)
//   TValue1  in   4  target tens digit (BCD)
//   TValue2  in   4  target units digit (BCD)
//   Motor    in   6  one-hot motor select, bit0 = motor 1
//   Step     out  6  step pulse per motor
//   Dir      out  6  direction per motor, 1 = increasing position
//   Busy     out  1  command in progress
//   Done     out  1  1-cycle pulse, target reached
//   Err      out  1  1-cycle pulse, command rejected (no motion)
//
// States:
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   S_IDLE    | waiting for a Start rising edge
//   S_LOAD    | BCD -> binary conversion, motor index decode
//   S_CHECK   | validate command, compare against current position
//   S_STEP_HI | Step high for STEP_DIV cycles
//   S_STEP_LO | Step low for STEP_DIV cycles, position updated on entry
//   S_FIN     | Done pulse, release Busy
// ---------------------------------------------------------------------------
module motor_step_driver #(
  parameter int STEP_DIV = 1000,
  parameter int LIMIT    = 999
) (
  input  logic       sysclk,
  input  logic       rst,
  input  logic       Start,
  input  logic [3:0] TValue0,
  input  logic [3:0] TValue1,
  input  logic [3:0] TValue2,
  input  logic [5:0] Motor,
  output logic [5:0] Step,
  output logic [5:0] Dir,
  output logic       Busy,
  output logic       Done,
  output logic       Err
);

  localparam int            CW       = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(STEP_DIV - 1);
  localparam logic [9:0]    LIMIT_V  = 10'(LIMIT);

`ifdef SOFT_LIMIT_EN
  localparam logic LIMIT_CHK = 1'b1;
`else
  localparam logic LIMIT_CHK = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_STEP_HI,
    S_STEP_LO,
    S_FIN
  } state_t;

  state_t        state;
  logic          start_prev;
  logic [5:0]    motor_q;
  logic [3:0]    d0_q;
  logic [3:0]    d1_q;
  logic [3:0]    d2_q;
  logic [9:0]    target_q;
  logic [2:0]    idx_q;
  logic          cmd_ok_q;
  logic          up_q;
  logic [CW-1:0] cnt;
  logic [9:0]    pos [6];

  logic          cmd;
  logic [2:0]    idx_calc;
  logic [2:0]    ones;
  logic [9:0]    target_calc;
  logic          digits_ok;
  logic          cmd_ok_calc;
  logic [9:0]    pos_cur;

  assign cmd = Start & ~start_prev;

  // Motor decode: index of the last set bit plus a population count so
  // that zero or multiple selections can be rejected.
  always_comb begin
    idx_calc = 3'd0;
    ones     = 3'd0;
    for (int i = 0; i < 6; i++) begin
      if (motor_q[i]) begin
        idx_calc = 3'(i);
        ones     = ones + 3'd1;
      end
    end
  end

  // Invalid digits may overflow 10 bits here; such commands are rejected
  // anyway, so the wrapped value is never used.
  assign target_calc = 10'(d0_q) * 10'd100 + 10'(d1_q) * 10'd10 + 10'(d2_q);
  assign digits_ok   = (d0_q <= 4'd9) && (d1_q <= 4'd9) && (d2_q <= 4'd9);
  assign cmd_ok_calc = (ones == 3'd1) && digits_ok &&
                       !(LIMIT_CHK && (target_calc > LIMIT_V));

  // Position of the selected motor; explicit mux keeps the read in range.
  always_comb begin
    pos_cur = 10'd0;
    for (int i = 0; i < 6; i++) begin
      if (idx_q == 3'(i)) pos_cur = pos[i];
    end
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      start_prev <= 1'b0;
      motor_q    <= 6'd0;
      d0_q       <= 4'd0;
      d1_q       <= 4'd0;
      d2_q       <= 4'd0;
      target_q   <= 10'd0;
      idx_q      <= 3'd0;
      cmd_ok_q   <= 1'b0;
      up_q       <= 1'b0;
      cnt        <= '0;
      Step       <= 6'd0;
      Dir        <= 6'd0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      Err        <= 1'b0;
      for (int i = 0; i < 6; i++) pos[i] <= 10'd0;
    end else begin
      start_prev <= Start;
      Done       <= 1'b0;
      Err        <= 1'b0;

      case (state)
        S_IDLE: begin
          if (cmd) begin
            motor_q <= Motor;
            d0_q    <= TValue0;
            d1_q    <= TValue1;
            d2_q    <= TValue2;
            Busy    <= 1'b1;
            state   <= S_LOAD;
          end
        end

        S_LOAD: begin
          target_q <= target_calc;
          idx_q    <= idx_calc;
          cmd_ok_q <= cmd_ok_calc;
          state    <= S_CHECK;
        end

        S_CHECK: begin
          if (!cmd_ok_q) begin
            Err   <= 1'b1;
            Busy  <= 1'b0;
            state <= S_IDLE;
          end else if (target_q == pos_cur) begin
            Done  <= 1'b1;
            Busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            // motor_q is known one-hot here, so it doubles as the write mask.
            up_q  <= (target_q > pos_cur);
            Dir   <= (Dir & ~motor_q) | (motor_q & {6{target_q > pos_cur}});
            cnt   <= CNT_LOAD;
            state <= S_STEP_HI;
          end
        end

        // Step is registered from the state, so the visible pulse trails the
        // state by one cycle; that cycle is the Dir setup time.
        S_STEP_HI: begin
          Step <= motor_q;
          if (cnt == '0) begin
            cnt <= CNT_LOAD;
            for (int i = 0; i < 6; i++) begin
              if (idx_q == 3'(i)) pos[i] <= up_q ? pos[i] + 10'd1 : pos[i] - 10'd1;
            end
            state <= S_STEP_LO;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        S_STEP_LO: begin
          Step <= 6'd0;
          if (cnt == '0) begin
            if (pos_cur == target_q) begin
              state <= S_FIN;
            end else begin
              cnt   <= CNT_LOAD;
              state <= S_STEP_HI;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        S_FIN: begin
          Done  <= 1'b1;
          Busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
